// File: rtl/tile_ram_arbiter.sv
// tile_ram_arbiter
// Arbitrates the single port of the 32x24 tile colour RAM (one RRRGGGBB byte
// per 20x20 tile). There are three users of the port:
//   - the display read path, which owns the port during active video
//   - a host write port, accepted only outside active video and when no fill
//     is running
//   - a whole-screen fill engine, which writes one entry per non-active cycle
// Every RAM-side output is registered. A grant made in cycle N appears on
// ram_* in cycle N+1.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   active_video      high while the beam is inside the 640x480 area
//   disp_addr         tile address requested by the display path
//   host_valid/ready  host write handshake (ready is combinational)
//   host_addr/data    host write tile address and colour
//   host_err          one-cycle pulse after an out-of-range host write is dropped
//   fill_start        start a whole-screen fill with fill_color
//   fill_busy         a fill is in progress
//   fill_done         one-cycle pulse once the last entry has been written
//   ram_addr/we/wdata registered RAM port
// Optional build macro TILE_ARB_STATS_EN adds:
//   stats_clr         synchronous clear of the stall counter
//   host_stall_cnt    saturating count of cycles with host_valid && !host_ready

module tile_ram_arbiter #(
  parameter int unsigned TILES = 768,
  parameter int unsigned AW    = 10,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          active_video,
  input  logic [AW-1:0] disp_addr,
  input  logic          host_valid,
  output logic          host_ready,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_data,
  output logic          host_err,
  input  logic          fill_start,
  input  logic [DW-1:0] fill_color,
  output logic          fill_busy,
  output logic          fill_done,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata
`ifdef TILE_ARB_STATS_EN
  ,
  input  logic          stats_clr,
  output logic [15:0]   host_stall_cnt
`endif
);

  // One extra bit so the range check still works when TILES == 2**AW.
  localparam int unsigned AWX = AW + 1;
  localparam logic [AWX-1:0] TILES_X  = AWX'(TILES);
  localparam logic [AW-1:0]  LAST_PTR = AW'(TILES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] col_q, col_d;

  logic [AW-1:0] ram_addr_d;
  logic          ram_we_d;
  logic [DW-1:0] ram_wdata_d;
  logic          host_err_d;
  logic          fill_busy_d;
  logic          fill_done_d;

  logic          host_fire;
  logic          host_in_range;

  // A fill starting this cycle blocks the host so fill wins the tie.
  assign host_ready    = !active_video && !fill_busy && !fill_start;
  assign host_fire     = host_valid && host_ready;
  assign host_in_range = AWX'(host_addr) < TILES_X;

  // Next-state, fill pointer and RAM port decision.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    col_d       = col_q;
    ram_addr_d  = disp_addr;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata;
    host_err_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fill_start) begin
          state_d = ST_FILL;
          ptr_d   = '0;
          col_d   = fill_color;
        end
      end
      ST_FILL: begin
        // Active video pauses the fill with the pointer held.
        if (!active_video) begin
          ram_addr_d  = ptr_q;
          ram_we_d    = 1'b1;
          ram_wdata_d = col_q;
          if (ptr_q == LAST_PTR) begin
            state_d = ST_DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + AW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase

    // Out-of-range host writes still complete the handshake but are dropped.
    if (host_fire && (state_q != ST_FILL)) begin
      ram_addr_d = host_addr;
      if (host_in_range) begin
        ram_we_d    = 1'b1;
        ram_wdata_d = host_data;
      end else begin
        host_err_d = 1'b1;
      end
    end

    fill_busy_d = (state_d == ST_FILL);
    fill_done_d = (state_d == ST_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      ptr_q     <= '0;
      col_q     <= '0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      host_err  <= 1'b0;
      fill_busy <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      col_q     <= col_d;
      ram_addr  <= ram_addr_d;
      ram_we    <= ram_we_d;
      ram_wdata <= ram_wdata_d;
      host_err  <= host_err_d;
      fill_busy <= fill_busy_d;
      fill_done <= fill_done_d;
    end
  end

`ifdef TILE_ARB_STATS_EN
  // Host stall counter: the clear input wins over an increment, and the count saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_stall_cnt <= '0;
    end else if (stats_clr) begin
      host_stall_cnt <= '0;
    end else if (host_valid && !host_ready && (host_stall_cnt != 16'hFFFF)) begin
      host_stall_cnt <= host_stall_cnt + 16'd1;
    end
  end
`endif

endmodule
